debounce_multi: RTL and testbench

- Parametrised multi-channel push-button debouncer with its own sample-tick generator.
- Each asynchronous button input is synchronised, then sampled on a slow tick. A level change is accepted only after a programmable number of consecutive agreeing samples.
- Provides a clean level plus one-cycle rise/fall pulses per channel.
- Also provides the legacy square-wave debounce clock (de_clk) for existing consumers.
- Sits between board buttons/switches and the CPU I/O and control logic.

---
 rtl/debounce_multi_pkg.sv | 7 +
 rtl/debounce_multi_chan.sv | 51 +++++
 rtl/debounce_multi.sv | 70 +++++++
 tb/tb_debounce_multi.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/debounce_multi_pkg.sv
// Shared defaults for the multi-channel push-button debouncer.
package debounce_multi_pkg;

  localparam int DEB_TICK_DIV_DEFAULT = 262144;
  localparam int DEB_STABLE_DEFAULT   = 4;

endpackage

// File: rtl/debounce_multi_chan.sv
// One debounce channel: two-flop synchroniser, tick-sampled stability
// counter, accepted level and one-cycle rise/fall pulses.
module debounce_chan
  import debounce_multi_pkg::*;
#(
  parameter int   STABLE_CNT  = DEB_STABLE_DEFAULT,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic tick,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int             CW   = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0]  LAST = CW'(STABLE_CNT - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync_q <= {2{RESET_LEVEL}};
      cnt    <= '0;
      level  <= RESET_LEVEL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (tick) begin
        // Any sample agreeing with the current level discards progress.
        if (sync_q[1] == level) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          level <= sync_q[1];
          cnt   <= '0;
          rise  <= sync_q[1];
          fall  <= ~sync_q[1];
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: shared sample-tick generator, legacy de_clk
// square wave, and one debounce_chan per button input.
module debounce_multi
  import debounce_multi_pkg::*;
#(
  parameter int   CHANNELS    = 5,
  parameter int   TICK_DIV    = DEB_TICK_DIV_DEFAULT,
  parameter int   STABLE_CNT  = DEB_STABLE_DEFAULT,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                en,
  input  logic [CHANNELS-1:0] btn_i,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o,
  output logic                tick_o,
  output logic                de_clk
);

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("debounce_multi: TICK_DIV must be >= 2");
  end
  if (STABLE_CNT < 1) begin : g_bad_stable_cnt
    $error("debounce_multi: STABLE_CNT must be >= 1");
  end
  if (CHANNELS < 1) begin : g_bad_channels
    $error("debounce_multi: CHANNELS must be >= 1");
  end

  localparam int            TW   = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);

  logic [TW-1:0] tcnt;

  // tick_o is the registered wrap of tcnt; everything freezes while en=0.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      tcnt   <= '0;
      tick_o <= 1'b0;
      de_clk <= 1'b0;
    end else if (!en) begin
      tick_o <= 1'b0;
    end else if (tcnt == TMAX) begin
      tcnt   <= '0;
      tick_o <= 1'b1;
      de_clk <= ~de_clk;
    end else begin
      tcnt   <= tcnt + TW'(1);
      tick_o <= 1'b0;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_chan #(
      .STABLE_CNT  (STABLE_CNT),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_chan (
      .clk   (clk),
      .clr   (clr),
      .tick  (tick_o),
      .btn   (btn_i[i]),
      .level (level_o[i]),
      .rise  (rise_o[i]),
      .fall  (fall_o[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi with CHANNELS=2, TICK_DIV=4, STABLE_CNT=3.
module tb_debounce_multi;

  logic       clk = 1'b0;
  logic       clr;
  logic       en;
  logic [1:0] btn_i;
  logic [1:0] level_o;
  logic [1:0] rise_o;
  logic [1:0] fall_o;
  logic       tick_o;
  logic       de_clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // clock / reset
  always #5 clk = ~clk;

  debounce_multi #(
    .CHANNELS    (2),
    .TICK_DIV    (4),
    .STABLE_CNT  (3),
    .RESET_LEVEL (1'b0)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .en      (en),
    .btn_i   (btn_i),
    .level_o (level_o),
    .rise_o  (rise_o),
    .fall_o  (fall_o),
    .tick_o  (tick_o),
    .de_clk  (de_clk)
  );

  // driver: advance n clock edges, then settle 1 time unit past the edge
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // checker
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic seen;
  logic de_bad;

  initial begin
    clr   = 1'b1;
    en    = 1'b1;
    btn_i = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", 8'(level_o), 8'h00);
    chk("rst_pulse", 8'({rise_o, fall_o}), 8'h00);
    chk("rst_tick",  8'({tick_o, de_clk}), 8'h00);
    clr = 1'b0;

    // tick generation: ticks after edges 4, 8, ...
    cycles(3);
    chk("tick_e3", 8'(tick_o), 8'h0);
    cycles(1);
    chk("tick_e4", 8'({tick_o, de_clk}), 8'h3);
    cycles(1);
    chk("tick_e5", 8'(tick_o), 8'h0);
    cycles(3);
    chk("tick_e8", 8'({tick_o, de_clk}), 8'h2);
    chk("idle_level", 8'(level_o), 8'h00);

    // clean press on channel 0: accepted on edge 21
    btn_i = 2'b01;
    cycles(12);
    chk("press_e20_level", 8'(level_o), 8'h00);
    cycles(1);
    chk("press_e21_level", 8'(level_o), 8'h01);
    chk("press_e21_rise",  8'(rise_o),  8'h01);
    chk("press_e21_fall",  8'(fall_o),  8'h00);
    cycles(1);
    chk("press_e22_rise",  8'(rise_o),  8'h00);

    // bounce on channel 1: two high samples, one low sample, repeated
    seen = 1'b0;
    for (int p = 0; p < 7; p++) begin
      btn_i[1] = 1'b1;
      for (int k = 0; k < 8; k++) begin
        cycles(1);
        seen |= level_o[1] | rise_o[1] | fall_o[1];
      end
      btn_i[1] = 1'b0;
      for (int k = 0; k < 4; k++) begin
        cycles(1);
        seen |= level_o[1] | rise_o[1] | fall_o[1];
      end
    end
    chk("bounce_ch1_quiet", 8'(seen), 8'h0);
    chk("bounce_ch0_held",  8'(level_o), 8'h01);

    // channel 1 press, then simultaneous release of both channels
    btn_i = 2'b11;
    cycles(10);
    chk("both_e116_level", 8'(level_o), 8'h01);
    cycles(1);
    chk("both_e117_level", 8'(level_o), 8'h03);
    chk("both_e117_rise",  8'(rise_o),  8'h02);
    btn_i = 2'b00;
    cycles(11);
    chk("rel_e128_level", 8'(level_o), 8'h03);
    chk("rel_e128_fall",  8'(fall_o),  8'h00);
    cycles(1);
    chk("rel_e129_fall",  8'(fall_o),  8'h03);
    chk("rel_e129_level", 8'(level_o), 8'h00);
    chk("rel_e129_rise",  8'(rise_o),  8'h00);
    cycles(1);
    chk("rel_e130_fall",  8'(fall_o),  8'h00);

    // reset in the middle of a count (two differing samples already taken)
    btn_i = 2'b01;
    cycles(10);
    chk("pre_rst_tick", 8'({tick_o, de_clk}), 8'h3);
    clr = 1'b1;
    #1;
    chk("async_rst_tick",  8'({tick_o, de_clk}), 8'h0);
    chk("async_rst_level", 8'(level_o), 8'h00);
    chk("async_rst_pulse", 8'({rise_o, fall_o}), 8'h00);
    cycles(1);
    clr = 1'b0;
    cycles(4);
    chk("post_rst_tick", 8'({tick_o, de_clk}), 8'h3);
    cycles(8);
    chk("post_rst_e153_level", 8'(level_o), 8'h00);
    cycles(1);
    chk("post_rst_e154_level", 8'(level_o), 8'h01);
    chk("post_rst_e154_rise",  8'(rise_o),  8'h01);

    // enable hold in the middle of a release count
    btn_i = 2'b00;
    cycles(8);
    chk("en_pre_level", 8'(level_o), 8'h01);
    en     = 1'b0;
    seen   = 1'b0;
    de_bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycles(1);
      seen   |= tick_o;
      de_bad |= (de_clk !== 1'b1);
    end
    chk("en_hold_no_tick", 8'(seen), 8'h0);
    chk("en_hold_de_clk",  8'(de_bad), 8'h0);
    chk("en_hold_level",   8'(level_o), 8'h01);
    en = 1'b1;
    cycles(3);
    chk("en_resume_tick",  8'({tick_o, de_clk}), 8'h2);
    chk("en_resume_level", 8'(level_o), 8'h01);
    cycles(1);
    chk("en_accept_level", 8'(level_o), 8'h00);
    chk("en_accept_fall",  8'(fall_o),  8'h01);

    // report
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
